// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencer for a 16x-oversampling UART receiver.
// Gates the receiver enable, queues received bytes in a show-ahead FIFO,
// counts framing errors, re-arms after an error holdoff and drains an
// in-flight frame on shutdown.
module uart_rx_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned HOLDOFF    = 32,
    parameter int unsigned DRAIN_MAX  = 255,
    parameter int unsigned ERR_W      = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                stop,
    output logic                                rx_en,
    input  logic [7:0]                          rx_data,
    input  logic                                rx_done,
    input  logic                                rx_busy,
    input  logic                                rx_err,
    output logic [7:0]                          m_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
    output logic                                overflow,
    output logic [ERR_W-1:0]                    err_count,
    input  logic                                clr_stats,
    output logic [2:0]                          state_o
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CNT_MAX = (HOLDOFF > DRAIN_MAX) ? HOLDOFF : DRAIN_MAX;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               rx_en_nxt;

    logic               rx_err_q;
    logic               err_rise;
    logic               active_c;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               full;
    logic               pop;
    logic               push_req;
    logic               push_ok;
    logic               drop;

    assign err_rise = rx_err && !rx_err_q;
    assign state_o  = state;

    // State and holdoff/drain counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_OFF;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and counter logic; stop dominates start everywhere
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_OFF: begin
                if (start && !stop) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                state_nxt = stop ? ST_OFF : ST_RUN;
            end
            ST_RUN: begin
                if (err_rise) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = CNT_W'(HOLDOFF - 1);
                end else if (stop && !rx_busy) begin
                    state_nxt = ST_OFF;
                end else if (stop) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = CNT_W'(DRAIN_MAX - 1);
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = start ? ST_ARM : ST_OFF;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (rx_done || err_rise || cnt == '0) begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: receiver enable follows the state being entered
    always_comb begin
        rx_en_nxt = 1'b0;
        active_c  = 1'b0;
        case (state_nxt)
            ST_ARM, ST_RUN, ST_DRAIN: rx_en_nxt = 1'b1;
            default:                  rx_en_nxt = 1'b0;
        endcase
        case (state)
            ST_RUN, ST_DRAIN: active_c = 1'b1;
            default:          active_c = 1'b0;
        endcase
    end

    // Registered receiver enable, aligned with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_en <= 1'b0;
        end else begin
            rx_en <= rx_en_nxt;
        end
    end

    // Error edge detect and statistics; a clear beats a same-cycle update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_err_q  <= 1'b0;
            err_count <= '0;
            overflow  <= 1'b0;
        end else begin
            rx_err_q <= rx_err;
            if (clr_stats) begin
                err_count <= '0;
                overflow  <= 1'b0;
            end else begin
                if (err_rise && active_c && (err_count != {ERR_W{1'b1}})) begin
                    err_count <= err_count + ERR_W'(1);
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign full     = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign m_valid  = (fifo_level != '0);
    assign m_data   = mem[rd_ptr];
    assign pop      = m_valid && m_ready;
    assign push_req = rx_done && active_c;
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // Show-ahead byte FIFO; a push into a full FIFO is taken only alongside a pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= rx_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                fifo_level <= fifo_level + LVL_W'(1);
            end else if (pop && !push_ok) begin
                fifo_level <= fifo_level - LVL_W'(1);
            end
        end
    end

endmodule
